// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: op and state encodings, dram defaults.
// Used by mem_access_unit (MAU_ALIGN_CHECK_EN enables the alignment/range check).
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100,
        OP_SW  = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } mau_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

    localparam logic [31:0] DM_BASE_DEFAULT  = 32'h1001_0000;
    localparam int          DM_WORDS_DEFAULT = 2048;

    function automatic logic is_load(input mau_op_e op);
        return !(op inside {OP_SW, OP_SB, OP_SH});
    endfunction

    function automatic logic is_misaligned(input mau_op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lane_unit.sv
// Combinational lane logic: little-endian byte/halfword extraction with extension,
// and byte/halfword merge into a read word for sub-word stores.
module lane_unit
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  mau_op_e     op_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        store_o  = word_i;

        case (op_i)
            OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o = {24'h0, byte_sel};
            OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o = {16'h0, half_sel};
            default: load_o = word_i;
        endcase

        case (op_i)
            OP_SW: store_o = sdata_i;
            OP_SB: store_o[{lane_i, 3'b000} +: 8] = sdata_i[7:0];
            OP_SH: begin
                if (lane_i[1]) store_o[31:16] = sdata_i[15:0];
                else           store_o[15:0]  = sdata_i[15:0];
            end
            default: store_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end to dram: one request at a time, sub-word stores via read-modify-write.
// Define MAU_ALIGN_CHECK_EN to add the alignment/range check and the addr_err port.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEFAULT,
    parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
`ifdef MAU_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        dm_ena,
    output logic        dm_wena,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    mau_state_e  state_q, state_d;
    mau_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_val, store_val;

    lane_unit u_lane (
        .word_i  (dm_rdata),
        .lane_i  (addr_q[1:0]),
        .op_i    (op_q),
        .sdata_i (wdata_q),
        .load_o  (load_val),
        .store_o (store_val)
    );

`ifdef MAU_ALIGN_CHECK_EN
    localparam logic [32:0] DM_LIMIT = {1'b0, DM_BASE} + 33'(DM_WORDS) * 33'd4;

    logic err_q, err_d;
    logic req_bad;

    always_comb begin
        req_bad = is_misaligned(mau_op_e'(op), addr[1:0])
               || ({1'b0, addr} <  {1'b0, DM_BASE})
               || ({1'b0, addr} >= DM_LIMIT);
    end
`else
    // Without the check the dram geometry has no effect on the logic.
    logic cfg_unused;
    assign cfg_unused = ^{DM_BASE, 32'(DM_WORDS)};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MAU_ALIGN_CHECK_EN
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = mau_op_e'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
`ifdef MAU_ALIGN_CHECK_EN
                    err_d   = req_bad;
                    if (req_bad)                      state_d = ST_DONE;
                    else if (mau_op_e'(op) == OP_SW)  state_d = ST_WRITE;
                    else                              state_d = ST_READ;
`else
                    state_d = (mau_op_e'(op) == OP_SW) ? ST_WRITE : ST_READ;
`endif
                end
            end
            ST_READ: begin
                if (is_load(op_q)) begin
                    rdata_d = load_val;
                    state_d = ST_DONE;
                end else begin
                    // The merged word replaces the store data and is written next cycle.
                    wdata_d = store_val;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MAU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MAU_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode the state register only, so reset drops dm_wena at once.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        dm_ena   = (state_q == ST_READ);
        dm_wena  = (state_q == ST_WRITE);
        dm_addr  = (dm_ena || dm_wena) ? {addr_q[31:2], 2'b00} : 32'h0;
        dm_wdata = dm_wena ? wdata_q : 32'h0;
        rdata    = rdata_q;
`ifdef MAU_ALIGN_CHECK_EN
        addr_err = done && err_q;
`endif
    end

endmodule
